// File: rtl/prio_enc_pkg.sv
// Shared types and constants for the registered round-robin priority encoder.
package prio_enc_pkg;

  // Grant state: IDLE has no grant on y, HOLD presents a grant.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/prio_pick.sv
// Combinational masked pick: highest set index (rr=0) or first set index
// searching downward from start with wrap-around (rr=1).
module prio_pick #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  input  logic         rr,
  output logic [W-1:0] idx,
  output logic         found
);

  int pos;

  // Later loop iterations overwrite earlier ones, so the last hit is the winner.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    if (!rr) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          idx   = W'(i);
          found = 1'b1;
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        pos = (int'(start) + N - k) % N;
        if (req[pos]) begin
          idx   = W'(pos);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered priority encoder with request latching, fixed or round-robin
// selection and a valid/ready grant handshake.
// Optional feature macro: PRIO_ENC_OVF_EN enables the sticky overflow flag;
// without it ovf is tied low.
module prio_encoder_rr
  import prio_enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         mode,
  input  logic [N-1:0] x,
  output logic [W-1:0] y,
  output logic         valid,
  input  logic         ready,
  output logic [N-1:0] pend,
  output logic         ovf
);

  state_e       state_q, state_d;
  logic [W-1:0] y_q, y_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] onehot_y, clr, pick_req;
  logic [W-1:0] pick_start, pick_idx;
  logic         pick_found, accept;

  // After grant g is accepted, g becomes the lowest round-robin priority.
  function automatic logic [W-1:0] ptr_after(input logic [W-1:0] g);
    return (g == '0) ? W'(N - 1) : g - 1'b1;
  endfunction

  assign onehot_y = {{(N-1){1'b0}}, 1'b1} << y_q;
  assign accept   = (state_q == HOLD) && ready;
  assign clr      = accept ? onehot_y : '0;
  // A new request on a bit being cleared keeps it pending.
  assign pend_d   = (pend_q & ~clr) | (x & {N{en}});

  // Next selection sees only already-latched requests, minus the grant in flight.
  assign pick_req   = (state_q == HOLD) ? (pend_q & ~onehot_y) : pend_q;
  assign pick_start = accept ? ptr_after(y_q) : ptr_q;

  prio_pick #(.N(N)) u_pick (
    .req   (pick_req),
    .start (pick_start),
    .rr    (mode == MODE_RR),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Next-state logic: load a grant from IDLE, hold it until accepted, chain grants.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          y_d     = pick_idx;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ready) begin
          ptr_d = ptr_after(y_q);
          if (pick_found) y_d = pick_idx;
          else            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, grant, pointer and pending registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      ptr_q   <= W'(N - 1);
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
    end
  end

`ifdef PRIO_ENC_OVF_EN
  logic ovf_q, ovf_d;
  assign ovf_d = ovf_q | (|(x & {N{en}} & pend_q & ~clr));

  // Sticky overflow: a request re-arrived on a bit still pending and not being served.
  always_ff @(posedge clk) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign y     = y_q;
  assign valid = (state_q == HOLD);
  assign pend  = pend_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Scoreboard bench for prio_encoder_rr (N=8): expected grants are queued as
// stimulus is issued; a monitor pops and compares on every accepted grant.
module tb_prio_encoder_rr;
  import prio_enc_pkg::*;

  localparam int N = 8;
  localparam int W = 3;

`ifdef PRIO_ENC_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, en, mode, ready;
  logic [N-1:0] x;
  logic [W-1:0] y;
  logic         valid, ovf;
  logic [N-1:0] pend;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  prio_encoder_rr #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .x     (x),
    .y     (y),
    .valid (valid),
    .ready (ready),
    .pend  (pend),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic push(input int g);
    exp_q.push_back(W'(g));
  endtask

  // Monitor: every handshake seen before the next edge must match the queue head.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && valid && ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL grant_unexpected actual=%0d required=none", y);
      end else begin
        e = exp_q.pop_front();
        if (y !== e) begin
          errors++;
          $display("FAIL grant actual=%0d required=%0d", y, e);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; mode = MODE_FIXED; ready = 1'b1; x = '0;

    // Reset state
    tick(); tick();
    chk("rst_y", y, 0);
    chk("rst_valid", valid, 0);
    chk("rst_pend", pend, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;

    // Fixed mode, two requests served back to back
    push(5); push(2);
    x = 8'b0010_0100;
    tick();
    x = '0;
    chk("s1_pend", pend, 8'h24);
    chk("s1_valid_lat1", valid, 0);
    tick();
    chk("s1_valid_lat2", valid, 1);
    chk("s1_y_first", y, 5);
    tick();
    chk("s1_valid_b2b", valid, 1);
    chk("s1_y_second", y, 2);
    tick();
    chk("s1_valid_end", valid, 0);
    chk("s1_pend_end", pend, 0);

    // Fixed mode, held grant is stable while ready is low
    do_reset();
    ready = 1'b0;
    x = 8'h01;
    tick();
    x = '0;
    tick();
    chk("s2_valid", valid, 1);
    chk("s2_y_hold0", y, 0);
    x = 8'h80;
    tick();
    x = '0;
    chk("s2_y_hold1", y, 0);
    chk("s2_pend", pend, 8'h81);
    tick();
    chk("s2_y_hold2", y, 0);
    push(0); push(7);
    ready = 1'b1;
    tick();
    chk("s2_y_next", y, 7);
    tick();
    chk("s2_valid_end", valid, 0);

    // Round robin full sweep from ptr=N-1
    do_reset();
    mode = MODE_RR;
    for (int g = 7; g >= 0; g--) push(g);
    x = 8'hFF;
    tick();
    x = '0;
    tick();
    chk("s3_y_first", y, 7);
    for (int i = 0; i < 8; i++) tick();
    chk("s3_valid_end", valid, 0);
    chk("s3_pend_end", pend, 0);

    // Round robin re-pulse after grant 7 accepted: next grant is 6
    do_reset();
    push(7);
    x = 8'h80;
    tick();
    x = '0;
    tick();
    tick();
    chk("s3b_idle", valid, 0);
    push(6); push(5); push(4); push(3); push(2); push(1); push(0); push(7);
    x = 8'hFF;
    tick();
    x = '0;
    tick();
    chk("s3b_y_first", y, 6);
    for (int i = 0; i < 8; i++) tick();
    chk("s3b_valid_end", valid, 0);

    // en=0: no capture, but earlier pending bits are still served
    do_reset();
    mode = MODE_FIXED;
    ready = 1'b0;
    x = 8'h18;
    tick();
    en = 1'b0;
    x = 8'hFF;
    tick();
    chk("s4_pend_a", pend, 8'h18);
    chk("s4_y", y, 4);
    tick();
    chk("s4_pend_b", pend, 8'h18);
    push(4); push(3);
    ready = 1'b1;
    tick();
    tick();
    chk("s4_pend_served", pend, 0);
    chk("s4_valid_served", valid, 0);
    tick();
    chk("s4_pend_blocked", pend, 0);
    chk("s4_valid_blocked", valid, 0);
    x = '0;
    en = 1'b1;

    // Overflow: repeated request on a pending bit while not served
    do_reset();
    ready = 1'b0;
    x = 8'h08;
    tick();
    chk("s5_ovf_first", ovf, 0);
    tick();
    tick();
    x = '0;
    chk("s5_ovf_set", ovf, OVF_EXP);
    push(3);
    ready = 1'b1;
    tick();
    chk("s5_pend_clr", pend, 0);
    chk("s5_ovf_sticky", ovf, OVF_EXP);

    // Reset mid-operation, then pointer restarts at N-1
    do_reset();
    mode = MODE_RR;
    push(3);
    x = 8'h0F;
    tick();
    x = '0;
    tick();
    tick();
    ready = 1'b0;
    chk("s6_valid", valid, 1);
    chk("s6_y", y, 2);
    chk("s6_pend", pend, 8'h07);
    do_reset();
    chk("s6_rst_valid", valid, 0);
    chk("s6_rst_pend", pend, 0);
    chk("s6_rst_y", y, 0);
    chk("s6_rst_ovf", ovf, 0);
    ready = 1'b1;
    push(6); push(2);
    x = 8'h44;
    tick();
    x = '0;
    tick();
    chk("s6_y_after", y, 6);
    tick();
    tick();
    chk("s6_valid_end", valid, 0);

    tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prio_encoder_rr.md
# prio_encoder_rr

Parametrised, registered priority encoder with request latching, selectable fixed-priority or round-robin mode and a valid/ready output handshake. Successor to the combinational 8-to-3 encoder: it holds requests until they are served, presents one encoded index at a time to a downstream consumer, and serves as the interrupt/request front end of the processor datapath.

## Interface
- N, default 8: number of request lines; must be at least 2.
- W, default $clog2(N): width of the encoded index. Derived as a localparam; never overridden.
- clk input 1: single clock; all state updates on the rising edge.
- rst_n input 1: reset, synchronous and active-low.
- en input 1: request capture enable; when 0, new x bits are not latched.
- mode input 1: 0 = fixed priority (highest index wins), 1 = round robin.
- x input N: request lines, level-sampled each cycle.
- y output W: encoded index of the granted request.
- valid output 1: y holds a grant.
- ready input 1: consumer accepts y.
- pend output N: pending-request mask.
- ovf output 1: sticky overflow flag (see Configuration).

## Operation
- Pending register:
  - pend_next = (pend & ~clr) | (x & {N{en}}).
  - clr is one-hot of y when valid && ready; otherwise 0.
  - Set wins over clear on the same bit in the same cycle, so the bit stays pending.
- State machine, two states:
  - IDLE (valid=0): if pend != 0, select an index from pend, load y, set valid, go to HOLD. Otherwise stay in IDLE.
  - HOLD (valid=1): y and valid are held stable while ready=0.
    - On ready=1, clear pend[y] and update the round-robin pointer.
    - Then select from pend & ~onehot(y), using the pre-clear value. If non-zero, load the new y, keep valid=1 and stay in HOLD. If zero, drop valid and go to IDLE.
- Selection:
  - Fixed mode: the highest set index wins, consistent with the MSB-first priority of the 8-to-3 encoder.
  - Round-robin mode: search descending from ptr with wrap-around (ptr, ptr-1, …, 0, N-1, …).
  - After each accepted grant g, ptr = (g-1) mod N, so g becomes lowest priority.
  - ptr updates only on accepted grants, in either mode.
- mode or en changes never alter a y that is already held; they take effect at the next selection.
- en=0 does not block serving requests already pending.

## Timing
- Reset values (rst_n=0 at a rising edge): y=0, valid=0, pend=0, ptr=N-1, ovf=0, state IDLE.
- Reset mid-operation discards all pending requests and any held grant. valid is low in the cycle after the reset edge.
- Latency: a request is sampled at edge k and appears in pend after edge k. valid rises after edge k+1, i.e. 2 cycles from x to valid with the system idle.
- Throughput: one grant per cycle while ready is held high and pend stays non-zero. There is no bubble between consecutive grants.
- A request that arrives in the same cycle as the final accept is not visible to that selection. It produces valid 1 cycle later via IDLE.
- Outputs y, valid, pend and ovf are all registered; there is no combinational path from inputs to outputs.

## Configuration
- PRIO_ENC_OVF_EN:
  - Defined: ovf sets when x[i] && en && pend[i] && !clr[i] for any i (a request arrives on a bit that is already pending and not being served). ovf is sticky and cleared only by reset.
  - Undefined: the ovf port remains but is tied to 0, and no overflow logic is synthesised.

## Structure
- Package prio_enc_pkg holds:
  - the state enum {IDLE, HOLD};
  - the constants MODE_FIXED=1'b0 and MODE_RR=1'b1.
- Sub-module prio_pick (parameter N): a combinational masked pick.
  - Inputs: req[N-1:0], start[W-1:0], rr.
  - Outputs: idx[W-1:0], found.
  - When rr=0, start is ignored and the highest set index is returned.
  - Instantiated once inside prio_encoder_rr.

## Test plan
All scenarios use N=8.
- Fixed mode, en=1, ready=1, x=8'b0010_0100 for one cycle, then 0 → y=5 for 1 cycle, then y=2 for 1 cycle, then valid=0. Both grants are back to back; valid first rises 2 cycles after x.
- Fixed mode, ready=0, pend=8'h01 held, then x=8'h80 → y stays 0 until ready. Next grant is y=7.
- Round-robin mode, x=8'hFF pulsed once, ready=1 → grants in the order 7,6,5,4,3,2,1,0. Re-pulse after grant 7 is accepted with ptr=6 → next grant is 6, not 7.
- en=0, x=8'hFF → pend stays 0 and valid stays 0. Pending bits from before en fell are still served.
- With PRIO_ENC_OVF_EN defined: x[3] high for 3 cycles with ready=0 → ovf=1 and it stays 1 after pend clears. With the macro undefined, ovf=0 always.
- rst_n=0 asserted while valid=1 with pend=8'h0F → after that edge: valid=0, pend=0, y=0, ovf=0. The first grant after re-request uses ptr=7.
